// File: rtl/dipsw_debounce.sv
// dipsw_debounce
//   Conditions raw DIP-switch / pushbutton levels for the LED/DIP-switch PIO.
//   Each bit is brought into the clk domain through a two-flop synchroniser.
//   It is then debounced independently against a shared free-running tick
//   prescaler. A new level must persist for STABLE_TICKS ticks before it is
//   committed to sw_out. Each commit produces a registered one-cycle rise or
//   fall pulse, and 'changed' ORs all pulses together for interrupt or
//   edge-capture logic.
//
// Ports
//   clk         system clock, rising edge
//   reset       synchronous, active-high reset
//   sw_in       raw asynchronous switch levels   [WIDTH]
//   sw_out      debounced levels (PIO in_port)   [WIDTH]
//   rise_pulse  one-cycle pulse on 0->1 commit   [WIDTH]
//   fall_pulse  one-cycle pulse on 1->0 commit   [WIDTH]
//   changed     OR of all rise/fall pulses
module dipsw_debounce #(
    parameter int               WIDTH        = 5,
    parameter int               TICK_DIV     = 50000,
    parameter int               STABLE_TICKS = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE  = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] sw_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             changed
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int CW = $clog2(STABLE_TICKS);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(STABLE_TICKS - 1);

    logic [WIDTH-1:0]         s1, s2;
    logic [PW-1:0]            presc;
    logic                     tick;
    logic [WIDTH-1:0][CW-1:0] cnt;
    logic [WIDTH-1:0]         mism;
    logic [WIDTH-1:0]         commit;

    assign tick = (presc == PRESC_MAX);
    // A bit is pending while its synchronised level differs from the
    // committed one.
    assign mism = s2 ^ sw_out;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        // Commit on the tick that would take the count past STABLE_TICKS-1.
        assign commit[i] = mism[i] & tick & (cnt[i] == CNT_MAX);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1         <= RESET_VALUE;
            s2         <= RESET_VALUE;
            presc      <= '0;
            cnt        <= '0;
            sw_out     <= RESET_VALUE;
            rise_pulse <= '0;
            fall_pulse <= '0;
        end else begin
            s1    <= sw_in;
            s2    <= s1;
            presc <= tick ? '0 : presc + PW'(1);
            for (int i = 0; i < WIDTH; i++) begin
                // Any return to the committed level cancels the pending
                // change, even between ticks.
                if (!mism[i])
                    cnt[i] <= '0;
                else if (commit[i])
                    cnt[i] <= '0;
                else if (tick)
                    cnt[i] <= cnt[i] + CW'(1);
            end
            sw_out     <= sw_out ^ commit;
            // The pulses are registered alongside the commit, so each pulse
            // shows in the first cycle that sw_out holds the new level.
            rise_pulse <= commit & s2;
            fall_pulse <= commit & ~s2;
        end
    end

    assign changed = |(rise_pulse | fall_pulse);

endmodule

// File: tb/tb_dipsw_debounce.sv
// Directed scoreboard bench for dipsw_debounce (TICK_DIV=4, STABLE_TICKS=3).
// The stimulus thread pushes each expected edge event, together with the
// exact cycle it must appear in. The monitor pops one event on every cycle
// that shows a pulse.
module tb_dipsw_debounce;

    localparam int W   = 5;
    localparam int TD  = 4;
    localparam int ST  = 3;
    localparam int LAT = (ST - 1) * TD + 1;  // first mismatch tick -> visible commit

    typedef struct {
        logic [W-1:0] out;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        int           cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] sw_in = '0;
    logic [W-1:0] sw_out, rise_pulse, fall_pulse;
    logic         changed;

    exp_t sb[$];
    int   cyc = 0;
    int   rst_cyc = 0;
    int   nvec = 0;
    int   nmis = 0;

    dipsw_debounce #(
        .WIDTH(W), .TICK_DIV(TD), .STABLE_TICKS(ST), .RESET_VALUE('0)
    ) dut (
        .clk(clk), .reset(reset), .sw_in(sw_in), .sw_out(sw_out),
        .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .changed(changed)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Ticks occur in the cycles where (c - rst_cyc) % TD == TD-1.
    function automatic int first_tick(input int from);
        int c = from;
        while (((c - rst_cyc) % TD) != TD - 1) c++;
        return c;
    endfunction

    // Level applied in cycle n reaches s2 in cycle n+2.
    function automatic int commit_cyc(input int n);
        return first_tick(n + 2) + LAT;
    endfunction

    task automatic push(input logic [W-1:0] o, input logic [W-1:0] r,
                        input logic [W-1:0] f, input int c);
        exp_t e;
        e.out = o; e.rise = r; e.fall = f; e.cyc = c;
        sb.push_back(e);
    endtask

    task automatic apply(input logic [W-1:0] v, output int n);
        @(negedge clk);
        sw_in = v;
        n = cyc;
    endtask

    // Caller is at a negedge; reset is held for n clock edges.
    task automatic do_reset(input int n, input logic [W-1:0] v);
        reset = 1'b1;
        sw_in = v;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk("rst_state", {sw_out, rise_pulse, fall_pulse, changed}, '0);
        end
        reset = 1'b0;
        rst_cyc = cyc;
    endtask

    task automatic post_reset_hold();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("post_rst_out", {sw_out, changed}, '0);
        end
    endtask

    task automatic drain(input logic [W-1:0] want_out);
        for (int k = 0; k < 40 && sb.size() != 0; k++) @(negedge clk);
        if (sb.size() != 0) begin
            nvec++;
            nmis++;
            $display("FAIL drain: %0d events never seen (cycle %0d)", sb.size(), cyc);
            sb.delete();
        end
        repeat (3) @(negedge clk);
        chk("settled_out", sw_out, want_out);
    endtask

    // Monitor: every cycle that shows an edge must match the next expected one.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && (changed || (|rise_pulse) || (|fall_pulse))) begin
                chk("changed_or", changed, |(rise_pulse | fall_pulse));
                if (sb.size() == 0) begin
                    nvec++;
                    nmis++;
                    $display("FAIL unexpected_edge: rise %0h fall %0h out %0h, none expected (cycle %0d)",
                             rise_pulse, fall_pulse, sw_out, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("rise", rise_pulse, e.rise);
                    chk("fall", fall_pulse, e.fall);
                    chk("edge_out", sw_out, e.out);
                    chk("edge_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        int n;
        int c0;

        // 1: reset with all switches high, then the full debounce from reset.
        do_reset(3, 5'h1F);
        push(5'h1F, 5'h1F, 5'h00, commit_cyc(rst_cyc));
        post_reset_hold();
        drain(5'h1F);
        apply(5'h00, n);
        push(5'h00, 5'h00, 5'h1F, commit_cyc(n));
        drain(5'h00);

        // 2: clean edge on bit 0, both directions.
        apply(5'h01, n);
        push(5'h01, 5'h01, 5'h00, commit_cyc(n));
        drain(5'h01);
        apply(5'h00, n);
        push(5'h00, 5'h00, 5'h01, commit_cyc(n));
        drain(5'h00);

        // 3: bit 2 bounces every 3 cycles, then settles high.
        for (int k = 0; k < 13; k++) begin
            apply((k % 2 == 0) ? 5'h04 : 5'h00, n);
            if (k < 12) repeat (2) @(negedge clk);
        end
        push(5'h04, 5'h04, 5'h00, commit_cyc(n));
        drain(5'h04);
        apply(5'h00, n);
        push(5'h00, 5'h00, 5'h04, commit_cyc(n));
        drain(5'h00);

        // 4: 5-cycle glitch on bit 3 must never commit.
        apply(5'h08, n);
        repeat (4) @(negedge clk);
        apply(5'h00, n);
        repeat (20) @(negedge clk);
        chk("glitch_out", sw_out, 5'h00);

        // 5: three bits change together and must commit as one event.
        apply(5'h15, n);
        push(5'h15, 5'h15, 5'h00, commit_cyc(n));
        drain(5'h15);
        apply(5'h00, n);
        push(5'h00, 5'h00, 5'h15, commit_cyc(n));
        drain(5'h00);

        // 6: reset after two ticks of counting; the debounce restarts from scratch.
        apply(5'h02, n);
        c0 = first_tick(n + 2);
        while (cyc < c0 + TD + 1) @(negedge clk);
        chk("pre_rst_out", sw_out, 5'h00);
        do_reset(1, 5'h02);
        push(5'h02, 5'h02, 5'h00, commit_cyc(rst_cyc));
        post_reset_hold();
        drain(5'h02);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
